// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: aligns requests onto a word-wide single-port memory, big-endian lanes.
// Optional access timeout with bus error when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_opcode,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_en,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_we,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             stall,
    output logic             misalign_err,
    output logic             bus_err
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e           state_q;
    logic [5:0]       op_q;
    logic [1:0]       off_q;
    logic             ld_q;
    logic [TAG_W-1:0] tag_q;

    logic        is_load, is_store, is_half, is_word, misaligned;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        timeout;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (req_opcode)
            OpLb, OpLbu: is_load = 1'b1;
            OpLh, OpLhu: begin is_load = 1'b1;  is_half = 1'b1; end
            OpLw:        begin is_load = 1'b1;  is_word = 1'b1; end
            OpSb:        is_store = 1'b1;
            OpSh:        begin is_store = 1'b1; is_half = 1'b1; end
            OpSw:        begin is_store = 1'b1; is_word = 1'b1; end
            default:     ;
        endcase
        misaligned = (is_half & req_addr[0]) | (is_word & (|req_addr[1:0]));
    end

    // Byte offset 0 is the most significant lane (big-endian).
    always_comb begin
        st_we    = 4'b0000;
        st_wdata = req_wdata;
        if (is_word) begin
            st_we = 4'b1111;
        end else if (is_half) begin
            st_we    = req_addr[1] ? 4'b0011 : 4'b1100;
            st_wdata = {2{req_wdata[15:0]}};
        end else begin
            st_we    = 4'b1000 >> req_addr[1:0];
            st_wdata = {4{req_wdata[7:0]}};
        end
        if (!is_store) begin
            st_we = 4'b0000;
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[31:24];
            2'd1:    ld_byte = mem_rdata[23:16];
            2'd2:    ld_byte = mem_rdata[15:8];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (op_q)
            OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_data = {24'd0, ld_byte};
            OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q;

    // Counter is held at zero outside ACCESS, so it starts clean on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StAccess && !mem_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= '0;
            off_q        <= '0;
            ld_q         <= 1'b0;
            tag_q        <= '0;
            req_ready    <= 1'b1;
            mem_en       <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= '0;
            mem_wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            stall        <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid && (is_load || is_store)) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            state_q   <= StAccess;
                            op_q      <= req_opcode;
                            off_q     <= req_addr[1:0];
                            ld_q      <= is_load;
                            tag_q     <= req_tag;
                            req_ready <= 1'b0;
                            stall     <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= st_we;
                            mem_wdata <= st_wdata;
                        end
                    end
                end
                StAccess: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 4'b0000;
                        if (ld_q) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_data  <= ld_data;
                            resp_tag   <= tag_q;
                        end else begin
                            state_q   <= StIdle;
                            req_ready <= 1'b1;
                            stall     <= 1'b0;
                        end
                    end else if (timeout) begin
                        state_q   <= StIdle;
                        mem_en    <= 1'b0;
                        mem_we    <= 4'b0000;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                        bus_err   <= 1'b1;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    mem_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a byte-level reference model.
// Define MEM_ACCESS_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_tag = '0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        stall;
    logic        misalign_err;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .TAG_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_opcode(req_opcode),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_tag(req_tag),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_tag(resp_tag),
        .stall(stall),
        .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request and follow it to completion, comparing against the model.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] tag, input int dly, input logic [31:0] rd);
        int          size, off;
        bit          is_ld, is_signed, mis;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd, exp_rd, mask;
        size      = 0;
        is_ld     = 0;
        is_signed = 0;
        case (op)
            6'h20: begin size = 1; is_ld = 1; is_signed = 1; end
            6'h21: begin size = 2; is_ld = 1; is_signed = 1; end
            6'h23: begin size = 4; is_ld = 1; end
            6'h24: begin size = 1; is_ld = 1; end
            6'h25: begin size = 2; is_ld = 1; end
            6'h28: size = 1;
            6'h29: size = 2;
            6'h2B: size = 4;
            default: size = 0;
        endcase
        off    = int'(addr[1:0]);
        mis    = (size > 1) && (off % size != 0);
        exp_we = 4'b0000;
        if (!is_ld && size > 0 && !mis) begin
            for (int b = off; b < off + size; b++) exp_we[3 - b] = 1'b1;
        end
        exp_wd = (size == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
                 (size == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
        mask   = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        exp_rd = (rd >> (8 * (4 - off - size))) & mask;
        if (is_signed && ((exp_rd & ((mask >> 1) + 32'd1)) != 0)) exp_rd = exp_rd | ~mask;

        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_wdata  = wd;
        req_tag    = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;

        if (size == 0 || mis) begin
            @(negedge clk);
            check_eq("misalign_err", 32'(misalign_err), 32'(mis));
            check_eq("mem_en_noacc", 32'(mem_en), 32'd0);
            check_eq("req_ready_noacc", 32'(req_ready), 32'd1);
            check_eq("stall_noacc", 32'(stall), 32'd0);
            @(negedge clk);
            check_eq("misalign_pulse_end", 32'(misalign_err), 32'd0);
        end else begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                check_eq("mem_en", 32'(mem_en), 32'd1);
                check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("mem_we", 32'(mem_we), 32'(exp_we));
                if (!is_ld) check_eq("mem_wdata", mem_wdata, exp_wd);
                check_eq("stall_busy", 32'(stall), 32'd1);
                check_eq("req_ready_busy", 32'(req_ready), 32'd0);
                check_eq("bus_err_quiet", 32'(bus_err), 32'd0);
                mem_ready = (k == dly);
                mem_rdata = (k == dly) ? rd : $urandom;
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            @(negedge clk);
            check_eq("mem_en_done", 32'(mem_en), 32'd0);
            check_eq("resp_valid", 32'(resp_valid), 32'(is_ld));
            if (is_ld) begin
                check_eq("resp_data", resp_data, exp_rd);
                check_eq("resp_tag", 32'(resp_tag), 32'(tag));
                @(negedge clk);
                check_eq("resp_pulse_end", 32'(resp_valid), 32'd0);
            end
            check_eq("req_ready_back", 32'(req_ready), 32'd1);
            check_eq("stall_back", 32'(stall), 32'd0);
        end
    endtask

    logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h00, 6'h0F};

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // Directed cases from the test plan.
        run_txn(6'h20, 32'h0000_0103, 32'h0, 5'd3, 0, 32'h1234_56F0);
        run_txn(6'h25, 32'h0000_0202, 32'h0, 5'd4, 1, 32'hAAAA_8001);
        run_txn(6'h21, 32'h0000_0202, 32'h0, 5'd5, 0, 32'hAAAA_8001);
        run_txn(6'h23, 32'h0000_0200, 32'h0, 5'd6, 2, 32'hAAAA_8001);
        run_txn(6'h28, 32'h0000_0301, 32'h0000_00AB, 5'd0, 0, 32'h0);
        run_txn(6'h29, 32'h0000_0302, 32'h0000_1234, 5'd0, 0, 32'h0);
        run_txn(6'h23, 32'h0000_1002, 32'h0, 5'd7, 0, 32'h0);
        run_txn(6'h2B, 32'h0000_0404, 32'hDEAD_BEEF, 5'd0, 5, 32'h0);
        run_txn(6'h0F, 32'h0000_0500, 32'h0, 5'd1, 0, 32'h0);

        // Reset during the third ACCESS cycle abandons the load.
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = 6'h23;
        req_addr   = 32'h0000_0040;
        req_tag    = 5'd9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            check_eq("rst_no_resp", 32'(resp_valid), 32'd0);
            check_eq("rst_no_mem_en", 32'(mem_en), 32'd0);
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No mem_ready: bus error after TO access cycles, then a normal access.
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = 6'h23;
        req_addr   = 32'h0000_0080;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            check_eq("to_mem_en", 32'(mem_en), 32'd1);
            check_eq("to_bus_err_early", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        check_eq("to_bus_err", 32'(bus_err), 32'd1);
        check_eq("to_mem_en_drop", 32'(mem_en), 32'd0);
        check_eq("to_no_resp", 32'(resp_valid), 32'd0);
        check_eq("to_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check_eq("to_bus_err_end", 32'(bus_err), 32'd0);
        run_txn(6'h23, 32'h0000_0084, 32'h0, 5'd2, 0, 32'hCAFE_F00D);
        // mem_ready on the timeout cycle wins.
        run_txn(6'h21, 32'h0000_0086, 32'h0, 5'd2, int'(TO) - 1, 32'h1234_F00D);
`else
        // Without the timeout the access waits indefinitely.
        run_txn(6'h24, 32'h0000_0087, 32'h0, 5'd8, 3 * int'(TO), 32'h0102_03C4);
`endif

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = $urandom;
            run_txn(ops[$urandom_range(0, 9)], a, $urandom, 5'($urandom), $urandom_range(0, 4),
                    $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the pipeline's memory stage and the single-port data memory.
- Accepts one load/store request per transaction, checks alignment, and drives word-aligned memory accesses with big-endian byte-lane write enables.
- Holds the access until memory acknowledges, then returns a byte/half/word-extracted, sign- or zero-extended load result.
- Asserts stall to the pipeline while busy.

Parameters:
- TIMEOUT_CYCLES, 64: max ACCESS cycles before a bus error is raised (used only with the optional feature).
- TAG_W, 5: width of the destination-register tag carried from request to response.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE)
- req_opcode  in  6  opcode per Opcode.vh: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_tag  in  TAG_W  destination tag for loads
- mem_en  out  1  memory access active
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_we  out  4  byte write enables; bit 3 = bits 31:24 = byte offset 0
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1
- resp_valid  out  1  one-cycle load result pulse
- resp_data  out  32  extended load result
- resp_tag  out  TAG_W  latched req_tag
- stall  out  1  high whenever state != IDLE
- misalign_err  out  1  one-cycle pulse on a misaligned request
- bus_err  out  1  one-cycle pulse on a timeout; tied 0 when the feature is off

Behaviour:
- Reset: async on rst_n low. State = IDLE. All outputs 0 except req_ready = 1. Latched registers cleared. A transaction in flight is abandoned: mem_en drops immediately, no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1; a request is accepted when req_valid = 1.
  - Load/store opcode, aligned: latch opcode, addr, wdata, tag; go to ACCESS.
  - Alignment rules: halfword ops need addr[0] = 0; word ops need addr[1:0] = 0.
  - Misaligned: misalign_err pulses on the next cycle; no memory access; stay IDLE.
  - Non-memory opcode: request is consumed and ignored; no output change.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we, mem_wdata are registered and held stable until mem_ready.
  - mem_we = 0 for loads.
  - SB: mem_we = 4'b1000 >> off; mem_wdata = {4{wdata[7:0]}}.
  - SH: off 0 gives 4'b1100, off 2 gives 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 4'b1111; mem_wdata = wdata.
  - On mem_ready: the store returns to IDLE; the load captures the extracted mem_rdata and goes to RESP. mem_en drops the following cycle.
- RESP: resp_valid = 1 for exactly one cycle with resp_data and resp_tag; then IDLE.
- Load extraction (big-endian):
  - off 0 selects bits 31:24, off 1 bits 23:16, off 2 bits 15:8, off 3 bits 7:0.
  - Halfwords: off 0 selects 31:16, off 2 selects 15:0.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unmodified.
- Latency:
  - Accept at cycle N; ACCESS from N+1.
  - With mem_ready at N+1, a load gives resp_valid at N+2; a store is back in IDLE at N+2.
  - Each cycle without mem_ready adds one cycle.
- Ordering: req_ready = 0 in ACCESS and RESP; req_valid there is ignored, and the requester must hold the request.
- mem_ready outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready. At TIMEOUT_CYCLES:
  - mem_en drops.
  - bus_err pulses one cycle.
  - No resp_valid is issued.
  - FSM returns to IDLE.
  - mem_ready in the same cycle as the timeout takes priority and completes normally.
- Undefined: no counter; ACCESS waits indefinitely; bus_err held at 0.

Test Plan:
- LB, addr 0x103, mem_rdata 0x123456F0, mem_ready on the first ACCESS cycle -> mem_addr 0x100, mem_we 0000, resp_valid at accept+2, resp_data 0xFFFFFFF0.
- LHU addr 0x202, mem_rdata 0xAAAA8001 -> resp_data 0x00008001. LH same -> 0xFFFF8001. LW addr 0x200 -> 0xAAAA8001.
- SB addr 0x301, wdata 0x000000AB -> mem_we 0100, mem_wdata 0xABABABAB, mem_addr 0x300, no resp_valid. SH addr 0x302, wdata 0x1234 -> mem_we 0011, mem_wdata 0x12341234.
- LW addr 0x1002 -> misalign_err one-cycle pulse, mem_en stays 0, req_ready stays 1.
- mem_ready delayed 5 cycles -> mem_en, mem_addr, mem_we, mem_wdata stable and stall = 1 throughout. rst_n low in the 3rd ACCESS cycle -> mem_en 0 immediately, no resp_valid, req_ready 1.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready never asserted -> bus_err pulse after 8 ACCESS cycles, then IDLE. A following aligned LW completes normally.
